// File: rtl/core_pkg.sv
// Shared definitions for the core instruction sequencer: geometry, instruction
// bit positions, the NOP word, FSM encoding and instruction-field helpers.
package core_pkg;

    localparam int ROW         = 8;
    localparam int COL         = 8;
    localparam int LEN_KIJ     = 9;
    localparam int IN_W        = 6;
    localparam int OUT_W       = 4;
    localparam int LEN_NIJ     = IN_W * IN_W;
    localparam int LEN_ONIJ    = OUT_W * OUT_W;
    localparam int KGAP        = 8;
    localparam int DRN_TIMEOUT = 255;

    localparam logic [10:0] ACT_BASE = 11'd0;
    localparam logic [10:0] WGT_BASE = 11'd1024;
    localparam logic [10:0] OUT_BASE = 11'd1024;

    localparam int INST_ACC        = 33;
    localparam int INST_CEN_PMEM   = 32;
    localparam int INST_WEN_PMEM   = 31;
    localparam int INST_A_PMEM_LSB = 20;
    localparam int INST_CEN_XMEM   = 19;
    localparam int INST_WEN_XMEM   = 18;
    localparam int INST_A_XMEM_LSB = 7;
    localparam int INST_OFIFO_RD   = 6;
    localparam int INST_IFIFO_WR   = 5;
    localparam int INST_IFIFO_RD   = 4;
    localparam int INST_L0_RD      = 3;
    localparam int INST_L0_WR      = 2;
    localparam int INST_EXECUTE    = 1;
    localparam int INST_LOAD       = 0;

    localparam logic [33:0] INST_NOP = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WLD    = 4'd1,
        ST_WKER   = 4'd2,
        ST_WGAP   = 4'd3,
        ST_ALD    = 4'd4,
        ST_EXE    = 4'd5,
        ST_DRN    = 4'd6,
        ST_ACC    = 4'd7,
        ST_ACC_WB = 4'd8,
        ST_DONE   = 4'd9
    } seq_state_t;

    function automatic logic [33:0] set_xmem(input logic [33:0] w, input logic cen,
                                             input logic [10:0] a);
        logic [33:0] r;
        r = w;
        r[INST_CEN_XMEM] = cen;
        r[INST_A_XMEM_LSB +: 11] = a;
        return r;
    endfunction

    function automatic logic [33:0] set_pmem(input logic [33:0] w, input logic cen,
                                             input logic wen, input logic [10:0] a);
        logic [33:0] r;
        r = w;
        r[INST_CEN_PMEM] = cen;
        r[INST_WEN_PMEM] = wen;
        r[INST_A_PMEM_LSB +: 11] = a;
        return r;
    endfunction

endpackage

// File: rtl/core_inst_seq_if.sv
// Controller/core-facing bus of the instruction sequencer.
// stall_cnt exists only when SEQ_STALL_CNT_EN is defined.
interface core_inst_seq_if;

    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  kij_o;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    modport master (
        input  start, ofifo_valid,
        output inst, busy, done, error, kij_o
`ifdef SEQ_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output start, ofifo_valid,
        input  inst, busy, done, error, kij_o
`ifdef SEQ_STALL_CNT_EN
        , input stall_cnt
`endif
    );

endinterface

// File: rtl/core_inst_seq_addr.sv
// ACC-phase psum address generator: walks o (output pixel) and k (kernel tap)
// with incremental row/column offsets so no divider or general multiplier is needed.
module core_inst_seq_addr
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        step_k,
    input  logic        step_o,
    output logic [10:0] addr,
    output logic [3:0]  o_idx,
    output logic        k_last,
    output logic        o_last
);

    logic [3:0]  k_r;
    logic [1:0]  kc_r;
    logic [10:0] kbase_r;
    logic [10:0] kofs_r;
    logic [3:0]  o_r;
    logic [1:0]  oc_r;
    logic [10:0] obase_r;

    // addr = k*LEN_NIJ + (or+kr)*IN_W + (oc+kc), kept as three running partial sums
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r <= 4'd0; kc_r <= 2'd0; kbase_r <= 11'd0; kofs_r <= 11'd0;
            o_r <= 4'd0; oc_r <= 2'd0; obase_r <= 11'd0;
        end else if (clr) begin
            k_r <= 4'd0; kc_r <= 2'd0; kbase_r <= 11'd0; kofs_r <= 11'd0;
            o_r <= 4'd0; oc_r <= 2'd0; obase_r <= 11'd0;
        end else if (step_o) begin
            k_r <= 4'd0; kc_r <= 2'd0; kbase_r <= 11'd0; kofs_r <= 11'd0;
            o_r <= o_r + 4'd1;
            if (oc_r == 2'(OUT_W - 1)) begin
                oc_r    <= 2'd0;
                obase_r <= obase_r + 11'(IN_W - OUT_W + 1);
            end else begin
                oc_r    <= oc_r + 2'd1;
                obase_r <= obase_r + 11'd1;
            end
        end else if (step_k) begin
            k_r     <= k_r + 4'd1;
            kbase_r <= kbase_r + 11'(LEN_NIJ);
            if (kc_r == 2'd2) begin
                kc_r   <= 2'd0;
                kofs_r <= kofs_r + 11'(IN_W - 2);
            end else begin
                kc_r   <= kc_r + 2'd1;
                kofs_r <= kofs_r + 11'd1;
            end
        end else begin
            k_r <= k_r;
        end
    end

    assign addr   = kbase_r + obase_r + kofs_r;
    assign o_idx  = o_r;
    assign k_last = (k_r == 4'(LEN_KIJ - 1));
    assign o_last = (o_r == 4'(LEN_ONIJ - 1));

endmodule

// File: rtl/core_inst_seq.sv
// Per-layer 3x3 conv instruction sequencer: weight load, activation load, execute,
// psum drain into PMEM per kij, then the PMEM accumulate pass. Optional: SEQ_STALL_CNT_EN.
module core_inst_seq
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    core_inst_seq_if.master bus
);

    seq_state_t  state_r, state_s;
    logic [5:0]  cnt_r, cnt_s;
    logic [3:0]  kij_r, kij_s;
    logic [5:0]  rd_r, rd_s;
    logic [7:0]  wait_r, wait_s;
    logic        pend_r, pend_s;
    logic [10:0] pend_addr_r, pend_addr_s;
    logic [33:0] inst_s, inst_r;
    logic        err_set_s, clr_s, step_k_s, step_o_s;
    logic        busy_r, done_r, error_r;
    logic [3:0]  kij_o_r;
    logic        start_ok_s;
    logic [10:0] acc_addr_s;
    logic [3:0]  o_idx_s;
    logic        k_last_s, o_last_s;

    assign start_ok_s = bus.start && (state_r == ST_IDLE);

    core_inst_seq_addr u_addr (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_s),
        .step_k (step_k_s),
        .step_o (step_o_s),
        .addr   (acc_addr_s),
        .o_idx  (o_idx_s),
        .k_last (k_last_s),
        .o_last (o_last_s)
    );

    // Next-state and instruction decode for the current phase
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        kij_s       = kij_r;
        rd_s        = rd_r;
        wait_s      = wait_r;
        pend_s      = 1'b0;
        pend_addr_s = pend_addr_r;
        inst_s      = INST_NOP;
        err_set_s   = 1'b0;
        clr_s       = 1'b0;
        step_k_s    = 1'b0;
        step_o_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_WLD;
                    cnt_s   = 6'd0;
                    kij_s   = 4'd0;
                    clr_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WLD: begin
                // l0_wr trails the xmem read by one cycle for SRAM read latency
                inst_s = set_xmem(INST_NOP, cnt_r >= 6'(ROW), (cnt_r < 6'(ROW)) ?
                                  WGT_BASE + 11'(kij_r) * 11'(ROW) + 11'(cnt_r) : 11'd0);
                inst_s[INST_L0_WR] = (cnt_r != 6'd0);
                if (cnt_r == 6'(ROW)) begin
                    state_s = ST_WKER;
                    cnt_s   = 6'd0;
                end else begin
                    cnt_s = cnt_r + 6'd1;
                end
            end
            ST_WKER: begin
                inst_s[INST_L0_RD] = 1'b1;
                inst_s[INST_LOAD]  = 1'b1;
                if (cnt_r == 6'(COL - 1)) begin
                    state_s = ST_WGAP;
                    cnt_s   = 6'd0;
                end else begin
                    cnt_s = cnt_r + 6'd1;
                end
            end
            ST_WGAP: begin
                if (cnt_r == 6'(KGAP - 1)) begin
                    state_s = ST_ALD;
                    cnt_s   = 6'd0;
                end else begin
                    cnt_s = cnt_r + 6'd1;
                end
            end
            ST_ALD: begin
                inst_s = set_xmem(INST_NOP, cnt_r >= 6'(LEN_NIJ), (cnt_r < 6'(LEN_NIJ)) ?
                                  ACT_BASE + 11'(cnt_r) : 11'd0);
                inst_s[INST_L0_WR] = (cnt_r != 6'd0);
                if (cnt_r == 6'(LEN_NIJ)) begin
                    state_s = ST_EXE;
                    cnt_s   = 6'd0;
                end else begin
                    cnt_s = cnt_r + 6'd1;
                end
            end
            ST_EXE: begin
                inst_s[INST_L0_RD]   = 1'b1;
                inst_s[INST_EXECUTE] = 1'b1;
                if (cnt_r == 6'(LEN_NIJ - 1)) begin
                    state_s = ST_DRN;
                    rd_s    = 6'd0;
                    wait_s  = 8'd0;
                end else begin
                    cnt_s = cnt_r + 6'd1;
                end
            end
            ST_DRN: begin
                // The PMEM write of the previous read overlaps the next OFIFO read
                inst_s = set_pmem(INST_NOP, ~pend_r, ~pend_r, pend_r ? pend_addr_r : 11'd0);
                if (rd_r == 6'(LEN_NIJ)) begin
                    cnt_s = 6'd0;
                    if (kij_r == 4'(LEN_KIJ - 1)) begin
                        state_s = ST_ACC;
                    end else begin
                        state_s = ST_WLD;
                        kij_s   = kij_r + 4'd1;
                    end
                end else if (bus.ofifo_valid) begin
                    inst_s[INST_OFIFO_RD] = 1'b1;
                    pend_s      = 1'b1;
                    pend_addr_s = 11'(kij_r) * 11'(LEN_NIJ) + 11'(rd_r);
                    rd_s        = rd_r + 6'd1;
                    wait_s      = 8'd0;
                end else if (wait_r == 8'(DRN_TIMEOUT - 1)) begin
                    inst_s    = INST_NOP;
                    err_set_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    wait_s = wait_r + 8'd1;
                end
            end
            ST_ACC: begin
                inst_s = set_pmem(INST_NOP, 1'b0, 1'b1, acc_addr_s);
                inst_s[INST_ACC] = 1'b1;
                if (k_last_s) begin
                    state_s = ST_ACC_WB;
                end else begin
                    step_k_s = 1'b1;
                end
            end
            ST_ACC_WB: begin
                inst_s   = set_pmem(INST_NOP, 1'b0, 1'b0, OUT_BASE + 11'(o_idx_s));
                step_o_s = 1'b1;
                if (o_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and phase counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 6'd0;
            kij_r       <= 4'd0;
            rd_r        <= 6'd0;
            wait_r      <= 8'd0;
            pend_r      <= 1'b0;
            pend_addr_r <= 11'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            kij_r       <= kij_s;
            rd_r        <= rd_s;
            wait_r      <= wait_s;
            pend_r      <= pend_s;
            pend_addr_r <= pend_addr_s;
        end
    end

    // Registered outputs; error is sticky until the next accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_r  <= INST_NOP;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            kij_o_r <= 4'd0;
        end else begin
            inst_r  <= inst_s;
            busy_r  <= (state_r != ST_IDLE);
            done_r  <= (state_r == ST_DONE);
            error_r <= err_set_s | (error_r & ~start_ok_s);
            kij_o_r <= kij_r;
        end
    end

    assign bus.inst  = inst_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.error = error_r;
    assign bus.kij_o = kij_o_r;

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_r;

    // Saturating count of drain cycles spent waiting on the OFIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_r <= 16'd0;
        end else if (start_ok_s) begin
            stall_r <= 16'd0;
        end else if ((state_r == ST_DRN) && !bus.ofifo_valid && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign bus.stall_cnt = stall_r;
`endif

endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: a loop-nest model of one conv layer
// predicts every instruction word while the bench drives random ofifo_valid/start.
module tb_core_inst_seq;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [33:0] NOP = 34'h1_800C_0000;

    core_inst_seq_if bus();

    core_inst_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] word(input logic acc, input logic cenp, input logic wenp,
                                         input int ap, input logic cenx, input int ax,
                                         input logic ofrd, input logic l0rd, input logic l0wr,
                                         input logic exe, input logic ld);
        logic [10:0] a_p;
        logic [10:0] a_x;
        a_p = ap[10:0];
        a_x = ax[10:0];
        return {acc, cenp, wenp, a_p, cenx, 1'b1, a_x, ofrd, 1'b0, 1'b0, l0rd, l0wr, exe, ld};
    endfunction

    // One clock: drive inputs, then compare every output against the model
    task automatic step(input logic v, input logic s, input logic [33:0] exp_inst,
                        input logic exp_done, input logic exp_err, input int exp_kij,
                        input string tag);
        bus.ofifo_valid = v;
        bus.start       = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "/inst"},  bus.inst, exp_inst);
        check({tag, "/busy"},  34'(bus.busy), 34'd1);
        check({tag, "/done"},  34'(bus.done), 34'(exp_done));
        check({tag, "/error"}, 34'(bus.error), 34'(exp_err));
        check({tag, "/kij"},   34'(bus.kij_o), 34'(exp_kij));
    endtask

    function automatic logic rnd_start(input bit pulse);
        return pulse ? ($urandom_range(0, 3) == 0) : 1'b0;
    endfunction

    // mode 0: ofifo_valid high; 1: random; 2: stuck low in kij 0 drain
    task automatic run_layer(input int mode, input bit pulse, input int abort_kij,
                             output bit aborted);
        int stall;
        stall   = 0;
        aborted = 1'b0;
        bus.start = 1'b1;
        bus.ofifo_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("start_err_clr", 34'(bus.error), 34'd0);
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i <= 8; i++)
                step($urandom_range(0, 1), rnd_start(pulse),
                     word(0, 1, 1, 0, (i < 8) ? 1'b0 : 1'b1, (i < 8) ? 1024 + k * 8 + i : 0,
                          0, 0, i >= 1, 0, 0), 0, 0, k, "wld");
            for (int i = 0; i < 8; i++)
                step($urandom_range(0, 1), rnd_start(pulse),
                     word(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1), 0, 0, k, "wker");
            for (int i = 0; i < 8; i++)
                step($urandom_range(0, 1), rnd_start(pulse), NOP, 0, 0, k, "wgap");
            for (int t = 0; t <= 36; t++)
                step($urandom_range(0, 1), rnd_start(pulse),
                     word(0, 1, 1, 0, (t < 36) ? 1'b0 : 1'b1, (t < 36) ? t : 0,
                          0, 0, t >= 1, 0, 0), 0, 0, k, "ald");
            for (int i = 0; i < 36; i++) begin
                if (k == abort_kij && i == 10) begin
                    aborted = 1'b1;
                    return;
                end
                step($urandom_range(0, 1), rnd_start(pulse),
                     word(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0), 0, 0, k, "exe");
            end
            begin
                int  reads, pend, npend, waitc, wr_seen, iter;
                bit  v, fin, tmo;
                reads = 0; pend = -1; waitc = 0; wr_seen = 0; iter = 0; fin = 0;
                while (!fin) begin
                    iter++;
                    if (iter > 1000) begin
                        check("drn_bound", 34'(iter), 34'd1000);
                        aborted = 1'b1;
                        return;
                    end
                    v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (k != 0);
                    tmo = 1'b0;
                    npend = -1;
                    if (reads == 36) begin
                        fin = 1'b1;
                    end else if (v) begin
                        npend = k * 36 + reads;
                        reads++;
                        waitc = 0;
                    end else begin
                        waitc++;
                        tmo = (waitc == 255);
                    end
                    if (!v) stall++;
                    step(v, rnd_start(pulse),
                         tmo ? NOP : word(0, pend < 0, pend < 0, (pend < 0) ? 0 : pend, 1, 0,
                                          (reads_ok(reads, fin, v)), 0, 0, 0, 0),
                         0, tmo, k, "drn");
                    if (bus.inst[32] == 1'b0 && bus.inst[31] == 1'b0) wr_seen++;
                    if (tmo) begin
`ifdef SEQ_STALL_CNT_EN
                        check("stall_tmo", 34'(bus.stall_cnt), 34'(stall));
`endif
                        aborted = 1'b1;
                        return;
                    end
                    pend = npend;
                end
                check("drn_writes", 34'(wr_seen), 34'd36);
            end
        end
        for (int o = 0; o < 16; o++) begin
            for (int kk = 0; kk < 9; kk++) begin
                int a;
                a = kk * 36 + (o / 4 + kk / 3) * 6 + (o % 4 + kk % 3);
                step($urandom_range(0, 1), rnd_start(pulse),
                     word(1, 0, 1, a, 1, 0, 0, 0, 0, 0, 0), 0, 0, 8, "acc");
                if (o == 5 && kk == 4) check("acc_o5k4", 34'(bus.inst[30:20]), 34'd158);
            end
            step($urandom_range(0, 1), rnd_start(pulse),
                 word(0, 0, 0, 1024 + o, 1, 0, 0, 0, 0, 0, 0), 0, 0, 8, "accwb");
            if (o == 15) check("wb_o15", 34'(bus.inst[30:20]), 34'd1039);
        end
        step($urandom_range(0, 1), rnd_start(pulse), NOP, 1, 0, 8, "done");
        bus.ofifo_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_busy", 34'(bus.busy), 34'd0);
        check("post_done", 34'(bus.done), 34'd0);
        check("post_inst", bus.inst, NOP);
`ifdef SEQ_STALL_CNT_EN
        check("stall", 34'(bus.stall_cnt), 34'(stall));
`endif
    endtask

    // ofifo_rd is expected on a cycle that consumed a read (reads was just bumped)
    function automatic logic reads_ok(input int reads, input bit fin, input bit v);
        return !fin && v && (reads > 0);
    endfunction

    initial begin
        bit ab;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst",  bus.inst, NOP);
        check("rst_busy",  34'(bus.busy), 34'd0);
        check("rst_done",  34'(bus.done), 34'd0);
        check("rst_error", 34'(bus.error), 34'd0);
        check("rst_kij",   34'(bus.kij_o), 34'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // reset in the middle of EXE at kij 3
        run_layer(1, 1'b0, 3, ab);
        #2;
        reset = 1'b1;
        #1;
        check("abort_inst", bus.inst, NOP);
        check("abort_busy", 34'(bus.busy), 34'd0);
        check("abort_kij",  34'(bus.kij_o), 34'd0);
        @(posedge clk);
        #1;
        check("abort_inst2", bus.inst, NOP);
        check("abort_busy2", 34'(bus.busy), 34'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_layer(0, 1'b0, -1, ab);
        run_layer(1, 1'b0, -1, ab);

        // drain timeout with ofifo_valid stuck low
        run_layer(2, 1'b0, -1, ab);
        for (int i = 0; i < 3; i++) begin
            bus.ofifo_valid = 1'b0;
            @(posedge clk);
            #1;
            check("tmo_busy",  34'(bus.busy), 34'd0);
            check("tmo_done",  34'(bus.done), 34'd0);
            check("tmo_error", 34'(bus.error), 34'd1);
            check("tmo_inst",  bus.inst, NOP);
        end

        // start pulses while busy must be ignored
        run_layer(1, 1'b1, -1, ab);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
